// File: rtl/dmem_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_if : host and pipeline MEM-stage bundle for dmem_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
interface dmem_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int HOST_W = 32
) ();
  logic                  host_wr;
  logic                  host_rd;
  logic [ADDR_W-1:0]     host_addr;
  logic [HOST_W-1:0]     host_wdata;
  logic                  host_busy;
  logic [DATA_W-1:0]     host_rdata;
  logic                  host_rvalid;

  logic                  pipe_req;
  logic                  pipe_we;
  logic [ADDR_W-1:0]     pipe_addr;
  logic [DATA_W-1:0]     pipe_wdata;
  logic [DATA_W/8-1:0]   pipe_be;
  logic                  pipe_stall;
  logic [DATA_W-1:0]     pipe_rdata;
  logic                  pipe_rvalid;

  modport master (
    output host_wr, host_rd, host_addr, host_wdata,
    output pipe_req, pipe_we, pipe_addr, pipe_wdata, pipe_be,
    input  host_busy, host_rdata, host_rvalid,
    input  pipe_stall, pipe_rdata, pipe_rvalid
  );

  modport slave (
    input  host_wr, host_rd, host_addr, host_wdata,
    input  pipe_req, pipe_we, pipe_addr, pipe_wdata, pipe_be,
    output host_busy, host_rdata, host_rvalid,
    output pipe_stall, pipe_rdata, pipe_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter : single-port data memory shared by host and pipeline ports
// Revision 1.0
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 8,
  parameter int OUT_REG        = 0,
  parameter int MAX_HOST_BURST = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  dmem_if.slave     bus
);
  localparam int c_nbytes = DATA_W / 8;
  localparam int c_depth  = 2 ** ADDR_W;
  localparam int c_sw     = (MAX_HOST_BURST > 0) ? $clog2(MAX_HOST_BURST + 1) : 1;
  localparam logic [c_sw-1:0] c_streak_max = c_sw'(MAX_HOST_BURST);

  logic [DATA_W-1:0] mem_q [c_depth];

  logic [c_sw-1:0]   streak_q, streak_d;
  logic              host_req, force_pipe;
  logic              host_grant, pipe_grant;
  logic              host_wr_go, host_rd_go, pipe_wr_go, pipe_rd_go;
  logic [ADDR_W-1:0] acc_addr;

  logic              host_v1_q, pipe_v1_q;
  logic [DATA_W-1:0] host_rdata1_q, pipe_rdata1_q;

  // Pipeline is forced through only once the host has used its full burst.
  assign host_req   = bus.host_wr | bus.host_rd;
  assign force_pipe = (MAX_HOST_BURST != 0) && (streak_q == c_streak_max);
  assign pipe_grant = bus.pipe_req & (~host_req | force_pipe);
  assign host_grant = host_req & ~pipe_grant;

  assign bus.host_busy  = host_req & ~host_grant;
  assign bus.pipe_stall = bus.pipe_req & ~pipe_grant;

  assign host_wr_go = host_grant & bus.host_wr;
  assign host_rd_go = host_grant & ~bus.host_wr & bus.host_rd;
  assign pipe_wr_go = pipe_grant & bus.pipe_we;
  assign pipe_rd_go = pipe_grant & ~bus.pipe_we;
  assign acc_addr   = host_grant ? bus.host_addr : bus.pipe_addr;

  always_comb begin
    streak_d = streak_q;
    if (!bus.pipe_req || pipe_grant) begin
      streak_d = '0;
    end else if (host_grant && (MAX_HOST_BURST != 0) && (streak_q != c_streak_max)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Array holds no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (host_wr_go) begin
      mem_q[acc_addr] <= DATA_W'(bus.host_wdata);
    end else if (pipe_wr_go) begin
      for (int i = 0; i < c_nbytes; i++) begin
        if (bus.pipe_be[i]) begin
          mem_q[acc_addr][8*i +: 8] <= bus.pipe_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q      <= '0;
      host_v1_q     <= 1'b0;
      pipe_v1_q     <= 1'b0;
      host_rdata1_q <= '0;
      pipe_rdata1_q <= '0;
    end else begin
      streak_q  <= streak_d;
      host_v1_q <= host_rd_go;
      pipe_v1_q <= pipe_rd_go;
      if (host_rd_go) begin
        host_rdata1_q <= mem_q[acc_addr];
      end
      if (pipe_rd_go) begin
        pipe_rdata1_q <= mem_q[acc_addr];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              host_v2_q, pipe_v2_q;
      logic [DATA_W-1:0] host_rdata2_q, pipe_rdata2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          host_v2_q     <= 1'b0;
          pipe_v2_q     <= 1'b0;
          host_rdata2_q <= '0;
          pipe_rdata2_q <= '0;
        end else begin
          host_v2_q     <= host_v1_q;
          pipe_v2_q     <= pipe_v1_q;
          host_rdata2_q <= host_rdata1_q;
          pipe_rdata2_q <= pipe_rdata1_q;
        end
      end

      assign bus.host_rvalid = host_v2_q;
      assign bus.pipe_rvalid = pipe_v2_q;
      assign bus.host_rdata  = host_rdata2_q;
      assign bus.pipe_rdata  = pipe_rdata2_q;
    end else begin : g_no_out_reg
      assign bus.host_rvalid = host_v1_q;
      assign bus.pipe_rvalid = pipe_v1_q;
      assign bus.host_rdata  = host_rdata1_q;
      assign bus.pipe_rdata  = pipe_rdata1_q;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_arbiter : directed bench for dmem_arbiter (default, strict, OUT_REG)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 8;
  localparam int HOST_W = 32;
  localparam logic [63:0] W_HOST = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] W_PIPE = 64'h1122_3344_AAAA_AAAA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOST_W(HOST_W)) if0 ();
  dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOST_W(HOST_W)) if1 ();
  dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOST_W(HOST_W)) if2 ();

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_REG(0), .MAX_HOST_BURST(4))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(if0));
  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_REG(0), .MAX_HOST_BURST(0))
    u_strict (.clk(clk), .rst_n(rst_n), .bus(if1));
  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_REG(1), .MAX_HOST_BURST(4))
    u_oreg (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic idle_all();
    if0.host_wr = 0; if0.host_rd = 0; if0.host_addr = '0; if0.host_wdata = '0;
    if0.pipe_req = 0; if0.pipe_we = 0; if0.pipe_addr = '0; if0.pipe_wdata = '0; if0.pipe_be = '0;
    if1.host_wr = 0; if1.host_rd = 0; if1.host_addr = '0; if1.host_wdata = '0;
    if1.pipe_req = 0; if1.pipe_we = 0; if1.pipe_addr = '0; if1.pipe_wdata = '0; if1.pipe_be = '0;
    if2.host_wr = 0; if2.host_rd = 0; if2.host_addr = '0; if2.host_wdata = '0;
    if2.pipe_req = 0; if2.pipe_we = 0; if2.pipe_addr = '0; if2.pipe_wdata = '0; if2.pipe_be = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    checks++; if (if0.host_rvalid !== 1'b0) begin errors++; $display("FAIL rst_host_rvalid: got %b want 0", if0.host_rvalid); end
    checks++; if (if0.pipe_rvalid !== 1'b0) begin errors++; $display("FAIL rst_pipe_rvalid: got %b want 0", if0.pipe_rvalid); end
    checks++; if (if0.host_rdata !== 64'h0) begin errors++; $display("FAIL rst_host_rdata: got %h want 0", if0.host_rdata); end
    checks++; if (if0.pipe_rdata !== 64'h0) begin errors++; $display("FAIL rst_pipe_rdata: got %h want 0", if0.pipe_rdata); end
    checks++; if (if0.host_busy !== 1'b0) begin errors++; $display("FAIL rst_host_busy: got %b want 0", if0.host_busy); end
    checks++; if (if0.pipe_stall !== 1'b0) begin errors++; $display("FAIL rst_pipe_stall: got %b want 0", if0.pipe_stall); end
    checks++; if (if2.host_rvalid !== 1'b0 || if2.pipe_rdata !== 64'h0) begin
      errors++; $display("FAIL rst_oreg: got rvalid %b rdata %h want 0/0", if2.host_rvalid, if2.pipe_rdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_host_rw();
    @(negedge clk);
    if0.pipe_req = 1; if0.pipe_we = 1; if0.pipe_addr = 8'h10; if0.pipe_wdata = '1; if0.pipe_be = 8'hFF;
    @(negedge clk);
    if0.pipe_req = 0;
    if0.host_wr = 1; if0.host_addr = 8'h10; if0.host_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (if0.host_busy !== 1'b0) begin errors++; $display("FAIL hw_busy: got %b want 0", if0.host_busy); end
    @(negedge clk);
    checks++; if (if0.host_rvalid !== 1'b0) begin errors++; $display("FAIL hw_no_rvalid: got %b want 0", if0.host_rvalid); end
    if0.host_wr = 0; if0.host_rd = 1;
    @(negedge clk);
    checks++; if (if0.host_rvalid !== 1'b1) begin errors++; $display("FAIL hr_rvalid: got %b want 1", if0.host_rvalid); end
    checks++; if (if0.host_rdata !== W_HOST) begin errors++; $display("FAIL hr_rdata: got %h want %h", if0.host_rdata, W_HOST); end
    checks++; if (if0.pipe_rvalid !== 1'b0) begin errors++; $display("FAIL hr_pipe_quiet: got %b want 0", if0.pipe_rvalid); end
    if0.host_rd = 0;
    @(negedge clk);
    checks++; if (if0.host_rvalid !== 1'b0) begin errors++; $display("FAIL hr_pulse: got %b want 0", if0.host_rvalid); end
  endtask

  task automatic test_pipe_be();
    @(negedge clk);
    if0.pipe_req = 1; if0.pipe_we = 1; if0.pipe_addr = 8'h20;
    if0.pipe_wdata = 64'h1122334455667788; if0.pipe_be = 8'hFF;
    #1;
    checks++; if (if0.pipe_stall !== 1'b0) begin errors++; $display("FAIL ps_stall: got %b want 0", if0.pipe_stall); end
    @(negedge clk);
    if0.pipe_wdata = 64'hAAAAAAAAAAAAAAAA; if0.pipe_be = 8'h0F;
    @(negedge clk);
    if0.pipe_we = 0;
    @(negedge clk);
    checks++; if (if0.pipe_rvalid !== 1'b1) begin errors++; $display("FAIL pl_rvalid: got %b want 1", if0.pipe_rvalid); end
    checks++; if (if0.pipe_rdata !== W_PIPE) begin errors++; $display("FAIL pl_rdata: got %h want %h", if0.pipe_rdata, W_PIPE); end
    checks++; if (if0.host_rvalid !== 1'b0) begin errors++; $display("FAIL pl_host_quiet: got %b want 0", if0.host_rvalid); end
    checks++; if (if0.host_rdata !== W_HOST) begin errors++; $display("FAIL pl_host_hold: got %h want %h", if0.host_rdata, W_HOST); end
    if0.pipe_we = 1; if0.pipe_be = 8'h00; if0.pipe_wdata = '0;
    #1;
    checks++; if (if0.pipe_stall !== 1'b0) begin errors++; $display("FAIL be0_stall: got %b want 0", if0.pipe_stall); end
    @(negedge clk);
    if0.pipe_we = 0;
    @(negedge clk);
    checks++; if (if0.pipe_rvalid !== 1'b1 || if0.pipe_rdata !== W_PIPE) begin
      errors++; $display("FAIL be0_unchanged: got %b/%h want 1/%h", if0.pipe_rvalid, if0.pipe_rdata, W_PIPE); end
    if0.pipe_req = 0;
    @(negedge clk);
    checks++; if (if0.pipe_rvalid !== 1'b0) begin errors++; $display("FAIL pl_pulse: got %b want 0", if0.pipe_rvalid); end
  endtask

  task automatic test_starvation();
    logic pg;
    @(negedge clk);
    if0.host_rd = 1; if0.host_addr = 8'h10; if0.pipe_req = 1; if0.pipe_we = 0; if0.pipe_addr = 8'h20;
    if1.host_rd = 1; if1.host_addr = 8'h10; if1.pipe_req = 1; if1.pipe_we = 0; if1.pipe_addr = 8'h20;
    for (int i = 0; i < 10; i++) begin
      pg = ((i % 5) == 4);
      #1;
      checks++; if (if0.host_busy !== pg || if0.pipe_stall !== !pg) begin
        errors++; $display("FAIL burst_grant[%0d]: got busy %b stall %b want %b %b", i, if0.host_busy, if0.pipe_stall, pg, !pg); end
      checks++; if (if1.pipe_stall !== 1'b1 || if1.host_busy !== 1'b0) begin
        errors++; $display("FAIL strict_grant[%0d]: got stall %b busy %b want 1 0", i, if1.pipe_stall, if1.host_busy); end
      @(negedge clk);
      checks++; if (if0.host_rvalid !== !pg || if0.pipe_rvalid !== pg) begin
        errors++; $display("FAIL burst_rvalid[%0d]: got h %b p %b want %b %b", i, if0.host_rvalid, if0.pipe_rvalid, !pg, pg); end
      checks++; if ((pg ? if0.pipe_rdata : if0.host_rdata) !== (pg ? W_PIPE : W_HOST)) begin
        errors++; $display("FAIL burst_rdata[%0d]: got %h want %h", i, pg ? if0.pipe_rdata : if0.host_rdata, pg ? W_PIPE : W_HOST); end
    end
    if0.host_rd = 0; if0.pipe_req = 0;
    if1.host_rd = 0; if1.pipe_req = 0;
  endtask

  task automatic test_wr_rd_both();
    @(negedge clk);
    if0.host_wr = 1; if0.host_rd = 1; if0.host_addr = 8'h05; if0.host_wdata = 32'h7;
    @(negedge clk);
    checks++; if (if0.host_rvalid !== 1'b0) begin errors++; $display("FAIL both_no_rvalid: got %b want 0", if0.host_rvalid); end
    if0.host_wr = 0;
    @(negedge clk);
    checks++; if (if0.host_rvalid !== 1'b1 || if0.host_rdata !== 64'h7) begin
      errors++; $display("FAIL both_readback: got %b/%h want 1/7", if0.host_rvalid, if0.host_rdata); end
    if0.host_rd = 0;
  endtask

  task automatic test_out_reg();
    int  k;
    logic hv, pv;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      if2.host_wr = 1; if2.host_addr = 8'(8'h30 + a); if2.host_wdata = 32'(32'h100 + a);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      k  = j - 2;
      hv = (k >= 0) && (k % 2 == 0);
      pv = (k >= 0) && (k % 2 == 1);
      checks++; if (if2.host_rvalid !== hv || if2.pipe_rvalid !== pv) begin
        errors++; $display("FAIL oreg_rvalid[%0d]: got h %b p %b want %b %b", j, if2.host_rvalid, if2.pipe_rvalid, hv, pv); end
      if (k >= 0) begin
        checks++; if ((hv ? if2.host_rdata : if2.pipe_rdata) !== 64'(64'h100 + k)) begin
          errors++; $display("FAIL oreg_rdata[%0d]: got %h want %h", k, hv ? if2.host_rdata : if2.pipe_rdata, 64'h100 + k); end
      end
      if2.host_wr  = 0;
      if2.host_rd  = (j < 4) && (j % 2 == 0);
      if2.pipe_req = (j < 4) && (j % 2 == 1);
      if2.pipe_we  = 0;
      if2.host_addr = 8'(8'h30 + j);
      if2.pipe_addr = 8'(8'h30 + j);
    end
    @(negedge clk);
    checks++; if (if2.host_rvalid !== 1'b0 || if2.pipe_rvalid !== 1'b0) begin
      errors++; $display("FAIL oreg_drain: got h %b p %b want 0 0", if2.host_rvalid, if2.pipe_rvalid); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    if0.pipe_req = 1; if0.pipe_we = 0; if0.pipe_addr = 8'h20;
    if2.pipe_req = 1; if2.pipe_we = 0; if2.pipe_addr = 8'h31;
    @(negedge clk);
    checks++; if (if0.pipe_rvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_rvalid: got %b want 1", if0.pipe_rvalid); end
    if0.pipe_req = 0; if2.pipe_req = 0;
    rst_n = 1'b0;
    #1;
    checks++; if (if0.host_rvalid !== 0 || if0.pipe_rvalid !== 0 || if0.host_rdata !== 0 || if0.pipe_rdata !== 0) begin
      errors++; $display("FAIL mid_rst_out: got %b %b %h %h want all 0", if0.host_rvalid, if0.pipe_rvalid, if0.host_rdata, if0.pipe_rdata); end
    checks++; if (if2.pipe_rvalid !== 0 || if2.pipe_rdata !== 0 || if2.host_rdata !== 0) begin
      errors++; $display("FAIL mid_rst_oreg: got %b %h %h want all 0", if2.pipe_rvalid, if2.pipe_rdata, if2.host_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (if0.pipe_rvalid !== 1'b0 || if2.pipe_rvalid !== 1'b0) begin
        errors++; $display("FAIL mid_post_rvalid[%0d]: got %b %b want 0 0", i, if0.pipe_rvalid, if2.pipe_rvalid); end
    end
    if0.host_rd = 1; if0.host_addr = 8'h10;
    if2.host_rd = 1; if2.host_addr = 8'h30;
    @(negedge clk);
    if0.host_rd = 0; if2.host_rd = 0;
    checks++; if (if0.host_rvalid !== 1'b1 || if0.host_rdata !== W_HOST) begin
      errors++; $display("FAIL mid_intact: got %b/%h want 1/%h", if0.host_rvalid, if0.host_rdata, W_HOST); end
    @(negedge clk);
    checks++; if (if2.host_rvalid !== 1'b1 || if2.host_rdata !== 64'h100) begin
      errors++; $display("FAIL mid_intact_oreg: got %b/%h want 1/100", if2.host_rvalid, if2.host_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_host_rw();
    test_pipe_be();
    test_starvation();
    test_wr_rd_both();
    test_out_reg();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
